mem_stage_pipelined: RTL and testbench

Parametrised RISC-V MEM pipeline stage. It takes EX/MEM control and data, performs a data-memory access, resolves the branch (pc_src) and registers the MEM/WB outputs.
- Adds sized loads/stores (byte, half, word, dword) with sign/zero extension, byte-enable writes, misalignment detection and configurable memory latency, with upstream stall generation.
- Sits between the EX/MEM register and the writeback mux.

---
 rtl/mem_stage_pkg.sv | 33 +++
 rtl/mem_stage_pipelined_align.sv | 47 ++++
 rtl/mem_stage_pipelined.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage_pipelined.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the MEM pipeline stage.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {IDLE, BUSY} state_e;

    function automatic int unsigned off_w(input int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

    // Size comes from funct3[1:0]; offset is the byte offset within an entry, zero-padded.
    function automatic logic op_legal(input logic [2:0] f3, input logic [2:0] off,
                                      input logic xlen64, input logic rd, input logic wr);
        logic ok;
        ok = !(rd && wr) && (f3 != 3'b111);
        if (!xlen64 && (f3 == F3_D || f3 == F3_WU)) ok = 1'b0;
        case (f3[1:0])
            2'd1:    if (off[0]) ok = 1'b0;
            2'd2:    if (off[1:0] != 2'b00) ok = 1'b0;
            2'd3:    if (off != 3'b000) ok = 1'b0;
            default: ;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_pipelined_align.sv
// Byte-lane steering for stores and lane extraction plus extension for loads.
module load_store_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned OFF_W = 3
) (
    input  logic [2:0]        funct3_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [XLEN-1:0]   load_word_i,
    output logic [XLEN/8-1:0] byte_en_o,
    output logic [XLEN-1:0]   store_word_o,
    output logic [XLEN-1:0]   load_data_o
);
    localparam int unsigned NB = XLEN / 8;

    logic [7:0]       lane_mask;
    logic [OFF_W+2:0] bit_off;
    logic [XLEN-1:0]  lane;
    logic [63:0]      ext;

    always_comb begin
        bit_off = {offset_i, 3'b000};
        case (funct3_i[1:0])
            2'd0:    lane_mask = 8'h01;
            2'd1:    lane_mask = 8'h03;
            2'd2:    lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
        byte_en_o    = NB'(lane_mask) << offset_i;
        store_word_o = store_data_i << bit_off;
        lane         = load_word_i >> bit_off;
        // Extension is done at 64 bits and truncated, so one table serves both XLENs.
        case (funct3_i)
            F3_B:    ext = 64'($signed(lane[7:0]));
            F3_H:    ext = 64'($signed(lane[15:0]));
            F3_W:    ext = 64'($signed(lane[31:0]));
            F3_BU:   ext = 64'(lane[7:0]);
            F3_HU:   ext = 64'(lane[15:0]);
            F3_WU:   ext = 64'(lane[31:0]);
            default: ext = 64'(lane);
        endcase
        load_data_o = ext[XLEN-1:0];
    end

endmodule

// File: rtl/mem_stage_pipelined.sv
// RISC-V MEM stage: sized data-memory access with fixed latency, branch resolve, MEM/WB register.
module mem_stage_pipelined
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            mem_to_reg_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            branch_in,
    input  logic            zero_in,
    input  logic [2:0]      funct3_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] result_in,
    input  logic [XLEN-1:0] write_data_in,
    output logic            stall_out,
    output logic            pc_src,
    output logic            wb_valid,
    output logic            wb_mem_to_reg,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_read_data,
    output logic [XLEN-1:0] wb_result,
    output logic            misalign_err
);
    localparam int unsigned OFF_W = off_w(XLEN);
    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             l_m2r_q, l_m2r_d, l_read_q, l_read_d, l_write_q, l_write_d;
    logic [2:0]       l_f3_q, l_f3_d;
    logic [4:0]       l_rd_q, l_rd_d;
    logic [XLEN-1:0]  l_res_q, l_res_d, l_wdata_q, l_wdata_d;

    logic             wb_valid_q, wb_valid_d, wb_m2r_q, wb_m2r_d, wb_err_q, wb_err_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_rdata_q, wb_rdata_d, wb_res_q, wb_res_d;

    logic             busy, is_mem, legal, done;
    logic             op_m2r, op_read, op_write;
    logic [2:0]       op_f3;
    logic [4:0]       op_rd;
    logic [XLEN-1:0]  op_res, op_wdata;
    logic [ADDR_W-1:0] idx;
    logic [XLEN-1:0]  rd_word, st_word, ld_data;
    logic [NB-1:0]    be;
    logic [XLEN-1:0]  mem_q [2**ADDR_W];

    // In BUSY the latched copy drives the access; in IDLE the live inputs do.
    always_comb begin
        busy     = (state_q == BUSY);
        is_mem   = mem_read_in | mem_write_in;
        legal    = op_legal(funct3_in, 3'(result_in[OFF_W-1:0]), XLEN == 64,
                            mem_read_in, mem_write_in);
        op_m2r   = busy ? l_m2r_q   : mem_to_reg_in;
        op_read  = busy ? l_read_q  : mem_read_in;
        op_write = busy ? l_write_q : mem_write_in;
        op_f3    = busy ? l_f3_q    : funct3_in;
        op_rd    = busy ? l_rd_q    : rd_in;
        op_res   = busy ? l_res_q   : result_in;
        op_wdata = busy ? l_wdata_q : write_data_in;
        done     = busy ? (cnt_q == '0) : (in_valid & is_mem & legal & (MEM_LAT == 1));
        idx      = op_res[ADDR_W+OFF_W-1:OFF_W];
    end

    assign rd_word   = mem_q[idx];
    assign stall_out = rst_n & (busy ? (cnt_q != '0) : (in_valid & is_mem & legal & (MEM_LAT > 1)));
    assign pc_src    = rst_n & in_valid & branch_in & zero_in;

    load_store_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
        .funct3_i     (op_f3),
        .offset_i     (op_res[OFF_W-1:0]),
        .store_data_i (op_wdata),
        .load_word_i  (rd_word),
        .byte_en_o    (be),
        .store_word_o (st_word),
        .load_data_o  (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        l_m2r_d    = l_m2r_q;
        l_read_d   = l_read_q;
        l_write_d  = l_write_q;
        l_f3_d     = l_f3_q;
        l_rd_d     = l_rd_q;
        l_res_d    = l_res_q;
        l_wdata_d  = l_wdata_q;
        wb_valid_d = 1'b0;
        wb_err_d   = 1'b0;
        wb_m2r_d   = wb_m2r_q;
        wb_rd_d    = wb_rd_q;
        wb_rdata_d = wb_rdata_q;
        wb_res_d   = wb_res_q;
        if (done) begin
            wb_valid_d = 1'b1;
            wb_m2r_d   = op_m2r;
            wb_rd_d    = op_rd;
            wb_res_d   = op_res;
            wb_rdata_d = op_read ? ld_data : '0;
            state_d    = IDLE;
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (in_valid) begin
            if (!is_mem) begin
                wb_valid_d = 1'b1;
                wb_m2r_d   = mem_to_reg_in;
                wb_rd_d    = rd_in;
                wb_res_d   = result_in;
                wb_rdata_d = '0;
            end else if (!legal) begin
                wb_valid_d = 1'b1;
                wb_err_d   = 1'b1;
                wb_m2r_d   = 1'b0;
                wb_rd_d    = '0;
                wb_res_d   = result_in;
                wb_rdata_d = '0;
            end else begin
                l_m2r_d   = mem_to_reg_in;
                l_read_d  = mem_read_in;
                l_write_d = mem_write_in;
                l_f3_d    = funct3_in;
                l_rd_d    = rd_in;
                l_res_d   = result_in;
                l_wdata_d = write_data_in;
                state_d   = BUSY;
                cnt_d     = CNT_W'(MEM_LAT - 2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            l_m2r_q    <= 1'b0;
            l_read_q   <= 1'b0;
            l_write_q  <= 1'b0;
            l_f3_q     <= '0;
            l_rd_q     <= '0;
            l_res_q    <= '0;
            l_wdata_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_rdata_q <= '0;
            wb_res_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            l_m2r_q    <= l_m2r_d;
            l_read_q   <= l_read_d;
            l_write_q  <= l_write_d;
            l_f3_q     <= l_f3_d;
            l_rd_q     <= l_rd_d;
            l_res_q    <= l_res_d;
            l_wdata_q  <= l_wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_err_q   <= wb_err_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rd_q    <= wb_rd_d;
            wb_rdata_q <= wb_rdata_d;
            wb_res_q   <= wb_res_d;
        end
    end

    always_ff @(posedge clk) begin
        if (done && op_write) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= st_word[8*b +: 8];
            end
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_mem_to_reg = wb_m2r_q;
    assign wb_rd         = wb_rd_q;
    assign wb_read_data  = wb_rdata_q;
    assign wb_result     = wb_res_q;
    assign misalign_err  = wb_err_q;

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Randomised bench for mem_stage_pipelined: two instances (latency 2 and 4) against a byte-array model.
module tb_mem_stage_pipelined;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv [2], m2r [2], rdq [2], wrq [2], br [2], zr [2];
    logic [2:0]  f3 [2];
    logic [4:0]  rdn [2];
    logic [63:0] res [2], wd [2];

    logic        stall [2], pcs [2], wv [2], wm2r [2], err [2];
    logic [4:0]  wrd [2];
    logic [63:0] wrdata [2], wres [2];

    logic [7:0]  mm [2][8192];
    logic [4:0]  exp_rd [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_pipelined #(.XLEN(64), .ADDR_W(10), .MEM_LAT(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .mem_to_reg_in(m2r[0]),
        .mem_read_in(rdq[0]), .mem_write_in(wrq[0]), .branch_in(br[0]), .zero_in(zr[0]),
        .funct3_in(f3[0]), .rd_in(rdn[0]), .result_in(res[0]), .write_data_in(wd[0]),
        .stall_out(stall[0]), .pc_src(pcs[0]), .wb_valid(wv[0]), .wb_mem_to_reg(wm2r[0]),
        .wb_rd(wrd[0]), .wb_read_data(wrdata[0]), .wb_result(wres[0]), .misalign_err(err[0])
    );

    mem_stage_pipelined #(.XLEN(64), .ADDR_W(10), .MEM_LAT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .mem_to_reg_in(m2r[1]),
        .mem_read_in(rdq[1]), .mem_write_in(wrq[1]), .branch_in(br[1]), .zero_in(zr[1]),
        .funct3_in(f3[1]), .rd_in(rdn[1]), .result_in(res[1]), .write_data_in(wd[1]),
        .stall_out(stall[1]), .pc_src(pcs[1]), .wb_valid(wv[1]), .wb_mem_to_reg(wm2r[1]),
        .wb_rd(wrd[1]), .wb_read_data(wrdata[1]), .wb_result(wres[1]), .misalign_err(err[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s != 0) ? 4 : 2;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic bit legal_of(input logic r, input logic w, input logic [2:0] f,
                                    input logic [63:0] a);
        int unsigned sz;
        sz = 1 << f[1:0];
        return (f != 3'b111) && !(r && w) && ((a[2:0] & 3'(sz - 1)) == 3'b000);
    endfunction

    function automatic logic [63:0] model_load(input int s, input logic [63:0] a,
                                               input logic [2:0] f);
        int unsigned sz;
        logic [63:0] v;
        sz = 1 << f[1:0];
        v  = '0;
        for (int unsigned i = 0; i < sz; i++)
            v |= 64'(mm[s][13'(a[12:0] + i)]) << (8 * i);
        if (!f[2] && sz < 8 && v[8*sz-1]) v |= ~64'h0 << (8 * sz);
        return v;
    endfunction

    task automatic model_store(input int s, input logic [63:0] a, input logic [2:0] f,
                               input logic [63:0] d);
        int unsigned sz;
        sz = 1 << f[1:0];
        for (int unsigned i = 0; i < sz; i++)
            mm[s][13'(a[12:0] + i)] = d[8*i +: 8];
    endtask

    task automatic scramble(input int s);
        iv[s]  = 1'($urandom_range(0, 1));
        m2r[s] = 1'($urandom_range(0, 1));
        rdq[s] = 1'($urandom_range(0, 1));
        wrq[s] = 1'($urandom_range(0, 1));
        br[s]  = 1'($urandom_range(0, 1));
        zr[s]  = 1'($urandom_range(0, 1));
        f3[s]  = 3'($urandom_range(0, 7));
        rdn[s] = 5'($urandom());
        res[s] = rand64();
        wd[s]  = rand64();
    endtask

    task automatic zero_chk(input int s);
        check("rst_stall", stall[s], 0);
        check("rst_pc_src", pcs[s], 0);
        check("rst_wb_valid", wv[s], 0);
        check("rst_wb_m2r", wm2r[s], 0);
        check("rst_wb_rd", wrd[s], 0);
        check("rst_wb_rdata", wrdata[s], 0);
        check("rst_wb_result", wres[s], 0);
        check("rst_misalign", err[s], 0);
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic run_op(input int s, input logic v, input logic mt, input logic r,
                          input logic w, input logic b, input logic z, input logic [2:0] f,
                          input logic [4:0] d, input logic [63:0] a, input logic [63:0] wdat,
                          input bit scr);
        int lat = lat_of(s);
        bit is_mem = r | w;
        bit ok = legal_of(r, w, f, a);
        bit slow = v && is_mem && ok;
        logic [63:0] exp_data;
        iv[s] = v; m2r[s] = mt; rdq[s] = r; wrq[s] = w; br[s] = b; zr[s] = z;
        f3[s] = f; rdn[s] = d; res[s] = a; wd[s] = wdat;
        @(negedge clk);
        check("pc_src", pcs[s], v & b & z);
        check("stall_accept", stall[s], slow && lat > 1);
        if (slow) begin
            for (int k = 1; k < lat; k++) begin
                @(posedge clk); #1;
                check("wb_valid_busy", wv[s], 0);
                if (scr) scramble(s);
                @(negedge clk);
                check("stall_busy", stall[s], k < lat - 1);
                check("pc_src_busy", pcs[s], iv[s] & br[s] & zr[s]);
            end
        end
        @(posedge clk); #1;
        if (!v) begin
            check("idle_wb_valid", wv[s], 0);
            check("idle_misalign", err[s], 0);
            check("idle_rd_hold", wrd[s], exp_rd[s]);
        end else if (!is_mem) begin
            check("alu_wb_valid", wv[s], 1);
            check("alu_wb_m2r", wm2r[s], mt);
            check("alu_wb_rd", wrd[s], d);
            check("alu_wb_result", wres[s], a);
            check("alu_wb_rdata", wrdata[s], 0);
            check("alu_misalign", err[s], 0);
            exp_rd[s] = d;
        end else if (!ok) begin
            check("bad_wb_valid", wv[s], 1);
            check("bad_wb_rd", wrd[s], 0);
            check("bad_misalign", err[s], 1);
            check("bad_wb_rdata", wrdata[s], 0);
            exp_rd[s] = '0;
        end else begin
            exp_data = r ? model_load(s, a, f) : 64'h0;
            if (w) model_store(s, a, f, wdat);
            check("mem_wb_valid", wv[s], 1);
            check("mem_wb_m2r", wm2r[s], mt);
            check("mem_wb_rd", wrd[s], d);
            check("mem_wb_result", wres[s], a);
            check("mem_wb_rdata", wrdata[s], exp_data);
            check("mem_misalign", err[s], 0);
            exp_rd[s] = d;
        end
        iv[s] = 1'b0;
    endtask

    initial begin
        int kind;
        logic [2:0] f;
        logic [7:0] base;
        logic [63:0] a;
        logic r, w;

        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            iv[s] = 0; m2r[s] = 0; rdq[s] = 0; wrq[s] = 0; br[s] = 0; zr[s] = 0;
            f3[s] = '0; rdn[s] = '0; res[s] = '0; wd[s] = '0; exp_rd[s] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        zero_chk(0);
        zero_chk(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Populate bytes 0x000-0x0FF of both memories so every later load has a known value.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++)
                run_op(s, 1, 0, 0, 1, 0, 0, 3'b011, 5'($urandom()),
                       (rand64() & ~64'h1FFF) | 64'(i * 8), rand64(), 0);

        run_op(0, 1, 0, 0, 1, 0, 0, 3'b011, 5'd1,  64'h40, 64'h1122334455667788, 0);
        run_op(0, 1, 1, 1, 0, 0, 0, 3'b011, 5'd5,  64'h40, 64'h0, 0);
        run_op(0, 1, 0, 0, 1, 0, 0, 3'b000, 5'd2,  64'h41, 64'hAAAA_AAAA_AAAA_AA80, 0);
        run_op(0, 1, 1, 1, 0, 0, 0, 3'b000, 5'd6,  64'h41, 64'h0, 0);
        run_op(0, 1, 1, 1, 0, 0, 0, 3'b100, 5'd7,  64'h41, 64'h0, 0);
        run_op(0, 1, 1, 1, 0, 0, 0, 3'b011, 5'd8,  64'h40, 64'h0, 0);
        run_op(0, 1, 1, 1, 0, 0, 0, 3'b010, 5'd9,  64'h42, 64'h0, 0);
        run_op(0, 1, 0, 0, 1, 0, 0, 3'b010, 5'd3,  64'h42, 64'hDEADBEEF, 0);
        run_op(0, 1, 1, 1, 0, 0, 0, 3'b011, 5'd10, 64'h40, 64'h0, 0);
        run_op(0, 1, 0, 0, 0, 1, 1, 3'b000, 5'd11, 64'h1234, 64'h0, 0);
        run_op(0, 1, 0, 0, 0, 1, 0, 3'b000, 5'd12, 64'h5678, 64'h0, 0);
        run_op(0, 0, 0, 0, 0, 1, 1, 3'b000, 5'd13, 64'h9999, 64'h0, 0);
        run_op(1, 1, 0, 0, 1, 0, 0, 3'b011, 5'd14, 64'h48, 64'h0102030405060708, 1);
        run_op(1, 1, 1, 1, 0, 0, 0, 3'b011, 5'd15, 64'h48, 64'h0, 1);
        run_op(1, 1, 1, 1, 0, 0, 0, 3'b110, 5'd16, 64'h4C, 64'h0, 1);

        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 60; n++) begin
                kind = $urandom_range(0, 11);
                f    = 3'($urandom_range(0, 7));
                base = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) base = base & ~8'((1 << f[1:0]) - 1);
                a = (rand64() & ~64'h1FFF) | 64'(base);
                if (kind >= 10) a = rand64();
                r = (kind >= 1 && kind <= 5) || kind == 9;
                w = (kind >= 6 && kind <= 9);
                run_op(s, kind != 0, 1'($urandom_range(0, 1)), r, w,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f,
                       5'($urandom()), a, rand64(), 1'($urandom_range(0, 1)));
            end
        end

        // Reset in the middle of a latency-4 store: the store must not reach memory.
        iv[1] = 1; m2r[1] = 0; rdq[1] = 0; wrq[1] = 1; br[1] = 0; zr[1] = 0;
        f3[1] = 3'b011; rdn[1] = 5'd20; res[1] = 64'h80; wd[1] = 64'hCAFEF00DCAFEF00D;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        zero_chk(0);
        zero_chk(1);
        iv[1] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        @(posedge clk); #1;
        run_op(1, 0, 0, 0, 0, 0, 0, 3'b000, 5'd0,  64'h0,  64'h0, 0);
        run_op(1, 1, 1, 1, 0, 0, 0, 3'b011, 5'd21, 64'h80, 64'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
